// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate-extension stage: extension opcodes and
// the occupancy states of the OUT/SKID output buffer.
package imm_ext_pkg;

    localparam int EXT_OP_W = 3;

    localparam logic [EXT_OP_W-1:0] EXT_ZERO    = 3'b000;
    localparam logic [EXT_OP_W-1:0] EXT_SIGNED  = 3'b001;
    localparam logic [EXT_OP_W-1:0] EXT_HIGHPOS = 3'b010;
    localparam logic [EXT_OP_W-1:0] EXT_BRANCH  = 3'b011;
    localparam logic [EXT_OP_W-1:0] EXT_JUMP    = 3'b100;
    localparam logic [EXT_OP_W-1:0] EXT_SHAMT   = 3'b101;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: turns the 26-bit instruction field into a
// DATA_W operand according to the extension opcode; flags unused opcodes.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [25:0]         field,
    input  logic [EXT_OP_W-1:0] op,
    output logic [DATA_W-1:0]   data,
    output logic                err
);

    logic [15:0]       imm_s;
    logic [DATA_W-1:0] sext_s;

    assign imm_s  = field[15:0];
    assign sext_s = {{(DATA_W-16){imm_s[15]}}, imm_s};

    // Opcode decode; shifting the sign-extended value keeps the sign above the
    // shifted field for both operand widths.
    always_comb begin
        data = '0;
        err  = 1'b0;
        case (op)
            EXT_ZERO:    data[15:0] = imm_s;
            EXT_SIGNED:  data       = sext_s;
            EXT_HIGHPOS: data       = sext_s << 5'd16;
            EXT_BRANCH:  data       = sext_s << 5'd2;
            EXT_JUMP:    data[27:0] = {field, 2'b00};
            EXT_SHAMT:   data[4:0]  = field[10:6];
            default:     err        = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a 2-entry OUT/SKID buffer,
// valid/ready handshakes on both sides and a synchronous flush.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [25:0]         in_field,
    input  logic [EXT_OP_W-1:0] in_op,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err
);

    logic [DATA_W-1:0] core_data_s;
    logic              core_err_s;
    logic              accept_s;
    logic              drain_s;
    logic              load_out_s;
    logic              load_skid_s;
    logic              skid_to_out_s;
    buf_state_e        state_r;
    buf_state_e        state_nxt_s;
    logic              skid_valid_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [TAG_W-1:0]  skid_tag_r;
    logic              skid_err_r;

    imm_ext_core #(.DATA_W(DATA_W)) u_core (
        .field (in_field),
        .op    (in_op),
        .data  (core_data_s),
        .err   (core_err_s)
    );

    assign accept_s = in_valid && in_ready;
    assign drain_s  = out_valid && out_ready;

    // Next buffer state and which register captures data this cycle.
    always_comb begin
        state_nxt_s   = state_r;
        load_out_s    = 1'b0;
        load_skid_s   = 1'b0;
        skid_to_out_s = 1'b0;
        case (state_r)
            BUF_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = BUF_ONE;
                    load_out_s  = 1'b1;
                end else begin
                    state_nxt_s = BUF_EMPTY;
                end
            end
            BUF_ONE: begin
                if (drain_s && accept_s) begin
                    state_nxt_s = BUF_ONE;
                    load_out_s  = 1'b1;
                end else if (drain_s) begin
                    state_nxt_s = BUF_EMPTY;
                end else if (accept_s) begin
                    state_nxt_s = BUF_FULL;
                    load_skid_s = 1'b1;
                end else begin
                    state_nxt_s = BUF_ONE;
                end
            end
            BUF_FULL: begin
                if (drain_s) begin
                    state_nxt_s   = BUF_ONE;
                    skid_to_out_s = 1'b1;
                end else begin
                    state_nxt_s = BUF_FULL;
                end
            end
            default: state_nxt_s = BUF_EMPTY;
        endcase
    end

    // Buffer registers; in_ready is registered from the next state so it never
    // depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= BUF_EMPTY;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_tag      <= '0;
            out_err      <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
            skid_tag_r   <= '0;
            skid_err_r   <= 1'b0;
        end else if (flush) begin
            state_r      <= BUF_EMPTY;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            in_ready     <= (state_nxt_s != BUF_FULL);
            out_valid    <= (state_nxt_s != BUF_EMPTY);
            skid_valid_r <= (state_nxt_s == BUF_FULL);
            if (load_out_s) begin
                out_data <= core_data_s;
                out_tag  <= in_tag;
                out_err  <= core_err_s;
            end else if (skid_to_out_s) begin
                out_data <= skid_data_r;
                out_tag  <= skid_tag_r;
                out_err  <= skid_err_r;
            end
            if (load_skid_s) begin
                skid_data_r <= core_data_s;
                skid_tag_r  <= in_tag;
                skid_err_r  <= core_err_s;
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: 32- and 64-bit instances share stimulus;
// a monitor pops expected items whenever an output transfer occurs.
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    typedef struct packed {
        logic [63:0] d32;
        logic [63:0] d64;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [25:0] field;
        logic [4:0]  tag;
        logic [63:0] e32;
        logic [63:0] e64;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [25:0] in_field = 26'd0;
    logic [2:0]  in_op = 3'd0;
    logic [4:0]  in_tag = 5'd0;
    logic        out_ready;
    logic        r32, r64, v32, v64, e32o, e64o;
    logic [31:0] d32o;
    logic [63:0] d64o;
    logic [4:0]  t32o, t64o;

    logic        ready_fixed = 1'b1;
    logic        rand_rdy = 1'b0;
    logic        skip_stab = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          wait_cnt = 0;
    int          acc_cnt = 0;
    exp_t        sb[$];
    vec_t        vecs[12];

    imm_ext_pipe #(.DATA_W(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
        .in_field(in_field), .in_op(in_op), .in_tag(in_tag), .out_valid(v32),
        .out_ready(out_ready), .out_data(d32o), .out_tag(t32o), .out_err(e32o)
    );

    imm_ext_pipe #(.DATA_W(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
        .in_field(in_field), .in_op(in_op), .in_tag(in_tag), .out_valid(v64),
        .out_ready(out_ready), .out_data(d64o), .out_tag(t64o), .out_err(e64o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference using signed arithmetic on a 64-bit value.
    function automatic exp_t model(input logic [2:0] op, input logic [25:0] f, input logic [4:0] tag);
        logic signed [15:0] imm;
        longint             s;
        logic [63:0]        r;
        imm = f[15:0];
        s   = imm;
        case (op)
            3'd0:    r = {48'd0, f[15:0]};
            3'd1:    r = s;
            3'd2:    r = s * 64'sd65536;
            3'd3:    r = s * 64'sd4;
            3'd4:    r = {38'd0, f} * 64'd4;
            3'd5:    r = {59'd0, f[10:6]};
            default: r = 64'd0;
        endcase
        model = {{32'd0, r[31:0]}, r, tag, op[2] & op[1]};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the item is accepted.
    task automatic send(input logic [2:0] op, input logic [25:0] field, input logic [4:0] tag,
                        input logic [63:0] x32, input logic [63:0] x64, input logic err);
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_field = field;
        in_tag   = tag;
        n = 0;
        @(negedge clk);
        while (!r32 && n < 50) begin
            wait_cnt++;
            n++;
            @(negedge clk);
        end
        if (!r32) begin
            check("send_timeout", 64'd0, 64'd1);
        end else begin
            sb.push_back({x32, x64, tag, err});
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Sole driver of out_ready; changes it just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    // Monitor: scoreboard pops on output transfers plus stall-stability checks.
    initial begin
        logic        stall;
        logic [31:0] hd;
        logic [4:0]  ht;
        logic        he;
        exp_t        e;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("ready_match", r64, r32);
                if (stall && !skip_stab) begin
                    check("stall_valid", v32, 1'b1);
                    check("stall_data", d32o, hd);
                    check("stall_tag", t32o, ht);
                    check("stall_err", e32o, he);
                end
                stall = v32 && !out_ready;
                hd = d32o;
                ht = t32o;
                he = e32o;
                if (v32 && out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_out", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("data32", d32o, e.d32);
                        check("tag32", t32o, e.tag);
                        check("err32", e32o, e.err);
                        check("valid64", v64, 1'b1);
                        check("data64", d64o, e.d64);
                        check("tag64", t64o, e.tag);
                        check("err64", e64o, e.err);
                    end
                end
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        exp_t m;
        vecs[0]  = {EXT_ZERO,    26'h0008001, 5'd1,  64'h0000_8001,          64'h0000_0000_0000_8001, 1'b0};
        vecs[1]  = {EXT_SIGNED,  26'h0008001, 5'd2,  64'hFFFF_8001,          64'hFFFF_FFFF_FFFF_8001, 1'b0};
        vecs[2]  = {EXT_HIGHPOS, 26'h0008001, 5'd3,  64'h8001_0000,          64'hFFFF_FFFF_8001_0000, 1'b0};
        vecs[3]  = {EXT_BRANCH,  26'h0008001, 5'd4,  64'hFFFE_0004,          64'hFFFF_FFFF_FFFE_0004, 1'b0};
        vecs[4]  = {EXT_JUMP,    26'h3FFFFFF, 5'd5,  64'h0FFF_FFFC,          64'h0000_0000_0FFF_FFFC, 1'b0};
        vecs[5]  = {EXT_SHAMT,   26'h00007C0, 5'd6,  64'h0000_001F,          64'h0000_0000_0000_001F, 1'b0};
        vecs[6]  = {3'b110,      26'h0001234, 5'd7,  64'h0,                  64'h0,                   1'b1};
        vecs[7]  = {3'b111,      26'h3FFFFFF, 5'd9,  64'h0,                  64'h0,                   1'b1};
        vecs[8]  = {EXT_SIGNED,  26'h0007FFF, 5'd10, 64'h0000_7FFF,          64'h0000_0000_0000_7FFF, 1'b0};
        vecs[9]  = {EXT_HIGHPOS, 26'h0008000, 5'd11, 64'h8000_0000,          64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[10] = {EXT_BRANCH,  26'h0007FFF, 5'd12, 64'h0001_FFFC,          64'h0000_0000_0001_FFFC, 1'b0};
        vecs[11] = {EXT_ZERO,    26'h3FF1234, 5'd31, 64'h0000_1234,          64'h0000_0000_0000_1234, 1'b0};

        // Reset values, then in_ready rises on the first edge after release.
        #12;
        check("rst_valid", v32, 1'b0);
        check("rst_data32", d32o, 32'd0);
        check("rst_data64", d64o, 64'd0);
        check("rst_tag", t32o, 5'd0);
        check("rst_err", e32o, 1'b0);
        cyc(1);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", r32, 1'b1);
        cyc(1);

        // Opcode sweep with out_ready held high.
        foreach (vecs[i]) send(vecs[i].op, vecs[i].field, vecs[i].tag, vecs[i].e32, vecs[i].e64, vecs[i].err);
        cyc(3);

        // Backpressure: tags 1..4 with a 3-cycle stall.
        ready_fixed = 1'b0;
        cyc(2);
        acc_cnt = 0;
        fork
            for (int t = 1; t <= 4; t++) send(EXT_ZERO, 26'(t), 5'(t), 64'(t), 64'(t), 1'b0);
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready", r32, 1'b0);
                check("bp_accepts", 64'(acc_cnt), 64'd2);
                ready_fixed = 1'b1;
            end
        join
        cyc(4);

        // Flush while FULL, with an input offered in the same cycle.
        ready_fixed = 1'b0;
        cyc(2);
        send(EXT_SIGNED, 26'h0001111, 5'd20, 64'h1111, 64'h1111, 1'b0);
        send(EXT_SIGNED, 26'h0002222, 5'd21, 64'h2222, 64'h2222, 1'b0);
        skip_stab = 1'b1;
        in_valid = 1'b1;
        in_op    = EXT_ZERO;
        in_field = 26'h0003333;
        in_tag   = 5'd22;
        flush    = 1'b1;
        cyc(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("flush_valid", v32, 1'b0);
        check("flush_ready", r32, 1'b1);
        ready_fixed = 1'b1;
        cyc(1);
        skip_stab = 1'b0;
        cyc(3);

        // Flush in EMPTY discards an input accepted on the same edge.
        in_valid = 1'b1;
        in_op    = EXT_ZERO;
        in_field = 26'h0004444;
        in_tag   = 5'd23;
        flush    = 1'b1;
        cyc(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_accept_valid", v32, 1'b0);
        cyc(3);

        // Asynchronous reset with one item held.
        ready_fixed = 1'b0;
        cyc(2);
        send(EXT_SIGNED, 26'h000ABCD, 5'd24, 64'hFFFF_ABCD, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0);
        skip_stab = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", v32, 1'b0);
        check("arst_data32", d32o, 32'd0);
        check("arst_data64", d64o, 64'd0);
        check("arst_tag", t32o, 5'd0);
        check("arst_err", e32o, 1'b0);
        sb.delete();
        ready_fixed = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("arst_ready", r32, 1'b1);
        skip_stab = 1'b0;
        cyc(2);

        // Random valid/ready traffic against the reference model.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  op;
            logic [25:0] f;
            logic [4:0]  tg;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            op = 3'($urandom_range(0, 7));
            f  = 26'($urandom);
            tg = 5'($urandom);
            m  = model(op, f, tg);
            send(op, f, tg, m.d32, m.d64, m.err);
        end
        rand_rdy = 1'b0;
        ready_fixed = 1'b1;
        cyc(6);

        // Full throughput with out_ready held high.
        wait_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            logic [25:0] f;
            f = 26'($urandom);
            m = model(EXT_BRANCH, f, 5'(i));
            send(EXT_BRANCH, f, 5'(i), m.d32, m.d64, m.err);
        end
        check("throughput_stalls", 64'(wait_cnt), 64'd0);
        cyc(5);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
